// File: rtl/npu_conv_seq.sv
// npu_conv_seq: bus-master sequencer for the npu conv engine.
// Loads weights and a sliding KxK image window from a byte-wide sync-read memory
// into the engine, fires one trigger per output position and streams packed results.
module npu_conv_seq #(
    parameter int unsigned IN_H     = 16,
    parameter int unsigned IN_W     = 15,
    parameter int unsigned K        = 3,
    parameter int unsigned W_BASE   = 240,
    parameter int unsigned WAIT_CYC = 4,
    parameter int unsigned PACK_N   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_bus_en,
    output logic        o_bus_we,
    output logic [15:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_res_data,
    output logic        o_res_valid,
    input  logic        i_res_ready
);

    localparam int unsigned RW = $clog2(IN_H);
    localparam int unsigned CW = $clog2(IN_W);
    localparam int unsigned PW = $clog2(PACK_N + 1);
    localparam int unsigned WW = $clog2(WAIT_CYC + 1);

    localparam logic [RW-1:0] LastRow  = RW'(IN_H - K);
    localparam logic [CW-1:0] LastCol  = CW'(IN_W - K);
    localparam logic [PW-1:0] PackFull = PW'(PACK_N);
    localparam logic [WW-1:0] WaitLast = WW'(WAIT_CYC - 1);

    // Column-load phases: 0..K-1 issue reads, 1..K shift bytes in, K+1 writes the column.
    localparam logic [2:0] PhRead  = 3'(K);
    localparam logic [2:0] PhWrite = 3'(K + 1);

    localparam logic [2:0] SelImg = 3'b001;
    localparam logic [2:0] SelWgt = 3'b010;
    localparam logic [2:0] SelCtl = 3'b100;
    localparam logic [2:0] SelRes = 3'b110;

    localparam logic [31:0] CtlTrig  = 32'h0000_0001;
    localparam logic [31:0] CtlImgClr = 32'h0000_0008;
    localparam logic [31:0] CtlAllClr = 32'h0000_003C;

    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StWld,
        StRow,
        StPrime,
        StCol,
        StTrig,
        StWait,
        StRdRes,
        StRdCap,
        StOut,
        StNext,
        StFlush,
        StDone
    } state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [2:0]    r_ph;
    logic [1:0]    r_kc;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [PW-1:0] r_pk;
    logic [WW-1:0] r_wait;
    logic [23:0]   r_colw;
    logic          r_rdv;
    logic [31:0]   r_res;
    logic          r_flush;

    logic          w_load_st;
    logic          w_rd_ph;
    logic          w_wr_ph;
    logic [15:0]   w_row_addr;
    logic [2:0]    w_sel;

    assign w_load_st  = (r_state == StWld) || (r_state == StPrime) || (r_state == StCol);
    assign w_rd_ph    = (r_ph < PhRead);
    assign w_wr_ph    = (r_ph == PhWrite);
    // Pixel row currently being read: the window's top row plus the read phase (kr).
    assign w_row_addr = (16'(r_row) + 16'(r_ph)) * 16'(IN_W);

    assign o_busy      = (r_state != StIdle);
    assign o_bus_addr  = {1'b0, w_sel, 12'h000};
    assign o_res_data  = r_res;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode and all bus/memory/stream strobes.
    always_comb begin
        w_state_d   = r_state;
        o_mem_rd    = 1'b0;
        o_mem_addr  = '0;
        o_bus_en    = 1'b0;
        o_bus_we    = 1'b0;
        w_sel       = 3'b000;
        o_bus_wdata = '0;
        o_res_valid = 1'b0;
        o_done      = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StClr;
                end
            end
            StClr: begin
                o_bus_en    = 1'b1;
                o_bus_we    = 1'b1;
                w_sel       = SelCtl;
                o_bus_wdata = CtlAllClr;
                w_state_d   = StWld;
            end
            StWld: begin
                if (w_rd_ph) begin
                    o_mem_rd   = 1'b1;
                    o_mem_addr = 16'(W_BASE) + 16'(r_ph) * 16'(K) + 16'(r_kc);
                end
                if (w_wr_ph) begin
                    o_bus_en    = 1'b1;
                    o_bus_we    = 1'b1;
                    w_sel       = SelWgt;
                    o_bus_wdata = {8'h00, r_colw};
                    if (r_kc == 2'(K - 1)) begin
                        w_state_d = StRow;
                    end
                end
            end
            StRow: begin
                o_bus_en    = 1'b1;
                o_bus_we    = 1'b1;
                w_sel       = SelCtl;
                o_bus_wdata = CtlImgClr;
                w_state_d   = StPrime;
            end
            StPrime: begin
                if (w_rd_ph) begin
                    o_mem_rd   = 1'b1;
                    o_mem_addr = w_row_addr + 16'(r_kc);
                end
                if (w_wr_ph) begin
                    o_bus_en    = 1'b1;
                    o_bus_we    = 1'b1;
                    w_sel       = SelImg;
                    o_bus_wdata = {8'h00, r_colw};
                    if (r_kc == 2'(K - 2)) begin
                        w_state_d = StCol;
                    end
                end
            end
            StCol: begin
                if (w_rd_ph) begin
                    o_mem_rd   = 1'b1;
                    o_mem_addr = w_row_addr + 16'(r_col) + 16'(K - 1);
                end
                if (w_wr_ph) begin
                    o_bus_en    = 1'b1;
                    o_bus_we    = 1'b1;
                    w_sel       = SelImg;
                    o_bus_wdata = {8'h00, r_colw};
                    w_state_d   = StTrig;
                end
            end
            StTrig: begin
                o_bus_en    = 1'b1;
                o_bus_we    = 1'b1;
                w_sel       = SelCtl;
                o_bus_wdata = CtlTrig;
                w_state_d   = StWait;
            end
            StWait: begin
                if (r_wait == WaitLast) begin
                    w_state_d = (r_pk == PackFull) ? StRdRes : StNext;
                end
            end
            StRdRes: begin
                o_bus_en  = 1'b1;
                w_sel     = SelRes;
                w_state_d = StRdCap;
            end
            StRdCap: begin
                w_state_d = StOut;
            end
            StOut: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    w_state_d = r_flush ? StDone : StNext;
                end
            end
            StNext: begin
                if (r_col == LastCol) begin
                    w_state_d = (r_row == LastRow) ? StFlush : StRow;
                end else begin
                    w_state_d = StCol;
                end
            end
            StFlush: begin
                w_state_d = (r_pk != '0) ? StRdRes : StDone;
            end
            StDone: begin
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Datapath: column assembly, position/pack/wait counters and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph    <= '0;
            r_kc    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_pk    <= '0;
            r_wait  <= '0;
            r_colw  <= '0;
            r_rdv   <= 1'b0;
            r_res   <= '0;
            r_flush <= 1'b0;
        end else begin
            r_rdv <= o_mem_rd;
            // Each byte arrives the cycle after its read; shifting right leaves kr=0 in [7:0].
            if (r_rdv) begin
                r_colw <= {i_mem_rdata, r_colw[23:8]};
            end
            r_ph <= (w_load_st && !w_wr_ph) ? r_ph + 3'd1 : 3'd0;

            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_pk    <= '0;
                        r_flush <= 1'b0;
                    end
                end
                StClr, StRow: begin
                    r_kc <= '0;
                end
                StWld, StPrime: begin
                    if (w_wr_ph) begin
                        r_kc <= r_kc + 2'd1;
                    end
                end
                StTrig: begin
                    r_pk   <= r_pk + PW'(1);
                    r_wait <= '0;
                end
                StWait: begin
                    r_wait <= r_wait + WW'(1);
                end
                StRdRes: begin
                    r_pk <= '0;
                end
                StRdCap: begin
                    r_res <= i_bus_rdata;
                end
                StNext: begin
                    if (r_col == LastCol) begin
                        // Hold at the final position; FLUSH takes over from here.
                        if (r_row != LastRow) begin
                            r_row <= r_row + RW'(1);
                            r_col <= '0;
                        end
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                StFlush: begin
                    r_flush <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
